logical_pipe: RTL and testbench

//  Pipelined, flow-controlled successor to the combinational logic unit.

---
 rtl/logical_pipe_pkg.sv | 17 +
 rtl/logical_pipe_if.sv | 29 ++
 rtl/logical_pipe_core.sv | 25 ++
 rtl/logical_pipe.sv | 85 ++++++++
 tb/tb_logical_pipe.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/logical_pipe_pkg.sv
// Shared types for the pipelined logic unit: op encoding and op field width.
package logical_pipe_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_NOR  = 3'b011,
        OP_NAND = 3'b100,
        OP_XNOR = 3'b101,
        OP_ANDN = 3'b110,
        OP_PASS = 3'b111
    } logic_op_e;

endpackage

// File: rtl/logical_pipe_if.sv
// Upstream issue beat and downstream result beat of the logic pipe, each with valid/ready.
interface logical_pipe_if
    import logical_pipe_pkg::*;
#(
    parameter int N = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [N-1:0]    A;
    logic [N-1:0]    B;
    logic [OP_W-1:0] op;
    logic            acc_use;
    logic            acc_ld;
    logic            out_valid;
    logic            out_ready;
    logic [N-1:0]    R;
    logic            zero;
    logic            parity;

    modport master (
        output in_valid, A, B, op, acc_use, acc_ld, out_ready,
        input  in_ready, out_valid, R, zero, parity
    );

    modport slave (
        input  in_valid, A, B, op, acc_use, acc_ld, out_ready,
        output in_ready, out_valid, R, zero, parity
    );
endinterface

// File: rtl/logical_pipe_core.sv
// Combinational bitwise function of X and B; every op code yields a defined result.
module logical_pipe_core
    import logical_pipe_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] b,
    input  logic_op_e    op,
    output logic [N-1:0] r
);
    always_comb begin
        r = x;
        case (op)
            OP_AND:  r = x & b;
            OP_OR:   r = x | b;
            OP_XOR:  r = x ^ b;
            OP_NOR:  r = ~(x | b);
            OP_NAND: r = ~(x & b);
            OP_XNOR: r = ~(x ^ b);
            OP_ANDN: r = x & ~b;
            OP_PASS: r = x;
        endcase
    end
endmodule

// File: rtl/logical_pipe.sv
// Pipelined logic unit: operand mux, accumulator updated at acceptance, and an
// elastic STAGES-deep chain carrying {valid, R, zero, parity}.
module logical_pipe
    import logical_pipe_pkg::*;
#(
    parameter int N      = 32,
    parameter int STAGES = 2
) (
    input  logic          clk,
    input  logic          reset,
    logical_pipe_if.slave bus
);
    logic [N-1:0]      acc;
    logic [N-1:0]      opx;
    logic [N-1:0]      res;
    logic              fire_in;
    logic [STAGES-1:0] ld;
    logic [STAGES-1:0] vld_p;
    logic [STAGES-1:0] zero_p;
    logic [STAGES-1:0] par_p;
    logic [N-1:0]      r_p [STAGES];

    assign opx = bus.acc_use ? acc : bus.A;

    logical_pipe_core #(.N(N)) u_core (
        .x  (opx),
        .b  (bus.B),
        .op (logic_op_e'(bus.op)),
        .r  (res)
    );

    // A stage loads when empty or when its successor takes its beat this cycle,
    // so bubbles collapse and the chain runs at one beat per cycle.
    always_comb begin
        ld = '0;
        ld[STAGES-1] = !vld_p[STAGES-1] || bus.out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            ld[k] = !vld_p[k] || ld[k+1];
        end
    end

    assign fire_in = bus.in_valid && ld[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc    <= '0;
            vld_p  <= '0;
            zero_p <= '1;
            par_p  <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_p[k] <= '0;
            end
        end else begin
            if (fire_in && bus.acc_ld) begin
                acc <= res;
            end
            // Stage 0: capture the beat at acceptance
            if (ld[0]) begin
                vld_p[0] <= bus.in_valid;
                if (bus.in_valid) begin
                    r_p[0]    <= res;
                    zero_p[0] <= ~|res;
                    par_p[0]  <= ^res;
                end
            end
            // Stages 1..STAGES-1: data moves only with a valid beat, keeping R steady
            for (int k = 1; k < STAGES; k++) begin
                if (ld[k]) begin
                    vld_p[k] <= vld_p[k-1];
                    if (vld_p[k-1]) begin
                        r_p[k]    <= r_p[k-1];
                        zero_p[k] <= zero_p[k-1];
                        par_p[k]  <= par_p[k-1];
                    end
                end
            end
        end
    end

    assign bus.in_ready  = ld[0];
    assign bus.out_valid = vld_p[STAGES-1];
    assign bus.R         = r_p[STAGES-1];
    assign bus.zero      = zero_p[STAGES-1];
    assign bus.parity    = par_p[STAGES-1];
endmodule

// File: tb/tb_logical_pipe.sv
// Bench for logical_pipe: STAGES=2 main build plus STAGES=1 and STAGES=4 builds,
// all driven from one stimulus and each scored against its own reference model.
`timescale 1ns/1ps
module tb_logical_pipe;
    localparam int N = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         in_valid;
    logic [N-1:0] a_in;
    logic [N-1:0] b_in;
    logic [2:0]   op_in;
    logic         acc_use;
    logic         acc_ld;
    logic         out_ready;
    logic         drain_chk = 1'b0;

    logic         main_ir;
    logic         main_ov;
    logic [N-1:0] main_r;
    logic         main_z;
    logic         main_p;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: the op table written directly from the function definitions
    function automatic logic [N-1:0] ref_fn(input logic [2:0] op, input logic [N-1:0] x,
                                             input logic [N-1:0] b);
        case (op)
            3'd0:    return x & b;
            3'd1:    return x | b;
            3'd2:    return x ^ b;
            3'd3:    return ~(x | b);
            3'd4:    return ~(x & b);
            3'd5:    return ~(x ^ b);
            3'd6:    return x & ~b;
            default: return x;
        endcase
    endfunction

    function automatic logic [N+1:0] beat_of(input logic [N-1:0] r);
        return {r, r == '0, ($countones(r) % 2) == 1};
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int ST = (gi == 0) ? 2 : ((gi == 1) ? 1 : 4);

        logical_pipe_if #(.N(N)) bus ();

        assign bus.in_valid  = in_valid;
        assign bus.A         = a_in;
        assign bus.B         = b_in;
        assign bus.op        = op_in;
        assign bus.acc_use   = acc_use;
        assign bus.acc_ld    = acc_ld;
        assign bus.out_ready = out_ready;

        logical_pipe #(.N(N), .STAGES(ST)) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus)
        );

        if (gi == 0) begin : g_main
            assign main_ir = bus.in_ready;
            assign main_ov = bus.out_valid;
            assign main_r  = bus.R;
            assign main_z  = bus.zero;
            assign main_p  = bus.parity;
        end

        logic [N+1:0] exp_q [$];
        int           cyc_q [$];
        logic [N-1:0] acc_m      = '0;
        int           cyc        = 0;
        int           last_stall = -1;
        logic         hold       = 1'b0;
        logic [N-1:0] hold_r     = '0;

        always @(negedge clk) begin : mon
            logic [N-1:0] rr;
            logic [N+1:0] e;
            int           c0;
            cyc++;
            if (drain_chk) check_eq($sformatf("drained_s%0d", ST), 32'(exp_q.size()), 32'd0);
            if (reset) begin
                exp_q.delete();
                cyc_q.delete();
                acc_m = '0;
                hold  = 1'b0;
                check_eq($sformatf("rst_outputs_s%0d", ST),
                         32'({bus.in_ready, bus.out_valid, bus.R, bus.zero, bus.parity}),
                         32'({1'b1, 1'b0, {N{1'b0}}, 1'b1, 1'b0}));
            end else begin
                if (hold) begin
                    check_eq($sformatf("hold_s%0d", ST), 32'({bus.out_valid, bus.R}),
                             32'({1'b1, hold_r}));
                end
                if (!bus.out_ready) last_stall = cyc;
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        check_eq($sformatf("extra_beat_s%0d", ST), 32'(bus.R), 32'hFFFF_FFFF);
                    end else begin
                        e  = exp_q.pop_front();
                        c0 = cyc_q.pop_front();
                        check_eq($sformatf("beat_s%0d", ST),
                                 32'({bus.R, bus.zero, bus.parity}), 32'(e));
                        if (last_stall < c0)
                            check_eq($sformatf("latency_s%0d", ST), 32'(cyc - c0), 32'(ST));
                    end
                end
                if (bus.in_valid && bus.in_ready) begin
                    rr = ref_fn(bus.op, bus.acc_use ? acc_m : bus.A, bus.B);
                    exp_q.push_back(beat_of(rr));
                    cyc_q.push_back(cyc);
                    if (bus.acc_ld) acc_m = rr;
                end
                hold   = bus.out_valid && !bus.out_ready;
                hold_r = bus.R;
            end
        end
    end

    logic [N+1:0] main_log [$];
    int           main_acc_cnt = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (main_ov && out_ready) main_log.push_back({main_r, main_z, main_p});
            if (in_valid && main_ir) main_acc_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2:0] op,
                        input logic use_acc, input logic ld_acc);
        int t;
        in_valid = 1'b1;
        a_in     = a;
        b_in     = b;
        op_in    = op;
        acc_use  = use_acc;
        acc_ld   = ld_acc;
        t        = 0;
        @(negedge clk);
        while (!main_ir && t < 50) begin
            t++;
            @(negedge clk);
        end
        if (t >= 50) check_eq("send_timeout", 32'd1, 32'd0);
        step();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        acc_use  = 1'b0;
        acc_ld   = 1'b0;
        repeat (n) step();
    endtask

    task automatic check_log(input string tag, input logic [N+1:0] exp_tab [$]);
        check_eq({tag, "_count"}, 32'(main_log.size()), 32'(exp_tab.size()));
        for (int i = 0; i < exp_tab.size() && i < main_log.size(); i++)
            check_eq($sformatf("%s_%0d", tag, i), 32'(main_log[i]), 32'(exp_tab[i]));
    endtask

    initial begin
        logic [N+1:0] tab [$];
        int idx;
        reset     = 1'b1;
        in_valid  = 1'b0;
        a_in      = '0;
        b_in      = '0;
        op_in     = '0;
        acc_use   = 1'b0;
        acc_ld    = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();
        check_eq("reset_state", 32'({main_ir, main_ov, main_r, main_z, main_p}),
                 32'({1'b1, 1'b0, 8'h00, 1'b1, 1'b0}));
        reset = 1'b0;
        step();

        // All eight ops on F0/3C back to back
        main_log.delete();
        for (int i = 0; i < 8; i++) send(8'hF0, 8'h3C, 3'(i), 1'b0, 1'b0);
        idle(6);
        tab = '{{8'h30, 2'b00}, {8'hFC, 2'b00}, {8'hCC, 2'b00}, {8'h03, 2'b00},
                {8'hCF, 2'b00}, {8'h33, 2'b00}, {8'hC0, 2'b00}, {8'hF0, 2'b00}};
        check_log("ops", tab);

        // Zero and parity flags
        main_log.delete();
        send(8'hAA, 8'h55, 3'd0, 1'b0, 1'b0);
        send(8'hAA, 8'h55, 3'd2, 1'b0, 1'b0);
        send(8'h01, 8'h55, 3'd7, 1'b0, 1'b0);
        idle(6);
        tab = '{{8'h00, 2'b10}, {8'hFF, 2'b00}, {8'h01, 2'b01}};
        check_log("flags", tab);

        // Accumulator chain, back to back
        main_log.delete();
        send(8'h0F, 8'h00, 3'd1, 1'b0, 1'b1);
        send(8'h00, 8'hF0, 3'd2, 1'b1, 1'b1);
        send(8'h77, 8'hFF, 3'd0, 1'b1, 1'b0);
        idle(6);
        tab = '{{8'h0F, 2'b00}, {8'hFF, 2'b00}, {8'hFF, 2'b00}};
        check_log("acc", tab);

        // Backpressure: only STAGES beats fit while output is blocked
        main_log.delete();
        out_ready    = 1'b0;
        main_acc_cnt = 0;
        idx          = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            a_in     = 8'h10 + 8'(idx);
            b_in     = 8'h00;
            op_in    = 3'd1;
            acc_use  = 1'b0;
            acc_ld   = 1'b0;
            @(negedge clk);
            if (main_ir) idx++;
            step();
        end
        check_eq("bp_accepted", 32'(main_acc_cnt), 32'd2);
        check_eq("bp_in_ready", 32'(main_ir), 32'd0);
        check_eq("bp_head", 32'({main_ov, main_r}), 32'({1'b1, 8'h10}));
        out_ready = 1'b1;
        while (idx < 6) begin
            send(8'h10 + 8'(idx), 8'h00, 3'd1, 1'b0, 1'b0);
            idx++;
        end
        idle(6);
        tab.delete();
        for (int i = 0; i < 6; i++) tab.push_back(beat_of(8'h10 + 8'(i)));
        check_log("bp", tab);

        // Reset mid-stream with beats in flight and a loaded accumulator
        send(8'h5A, 8'h00, 3'd1, 1'b0, 1'b1);
        idle(6);
        out_ready = 1'b0;
        send(8'h11, 8'h22, 3'd1, 1'b0, 1'b0);
        send(8'h33, 8'h44, 3'd1, 1'b0, 1'b0);
        idle(1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("async_rst", 32'({main_ir, main_ov, main_r, main_z, main_p}),
                 32'({1'b1, 1'b0, 8'h00, 1'b1, 1'b0}));
        repeat (2) step();
        reset     = 1'b0;
        out_ready = 1'b1;
        main_log.delete();
        step();
        send(8'hC3, 8'h00, 3'd7, 1'b1, 1'b0);
        idle(8);
        tab = '{{8'h00, 2'b10}};
        check_log("post_rst", tab);

        // Randomized traffic; unstalled opening phase exercises exact latency
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            a_in      = N'($urandom);
            b_in      = N'($urandom);
            op_in     = 3'($urandom_range(0, 7));
            acc_use   = 1'($urandom_range(0, 1));
            acc_ld    = 1'($urandom_range(0, 1));
            out_ready = (i < 600) ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (i == 1800) begin
                #2;
                reset = 1'b1;
                repeat (2) step();
                reset = 1'b0;
            end
            step();
        end
        idle(0);
        out_ready = 1'b1;
        repeat (12) step();
        drain_chk = 1'b1;
        step();
        drain_chk = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
